// File: rtl/axis_debug_reply_arbiter.sv
// axis_debug_reply_arbiter: frame-level round-robin merge of per-device debug reply streams
module axis_debug_reply_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int COUNT_WIDTH = 16,
    localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   i_clk_dbg,
    input  logic                   i_rst_n,
    input  logic [NUM_PORTS-1:0]   i_s_axis_tvalid,
    output logic [NUM_PORTS-1:0]   o_s_axis_tready,
    input  logic [NUM_PORTS*8-1:0] i_s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   i_s_axis_tlast,
    output logic                   o_m_axis_tvalid,
    input  logic                   i_m_axis_tready,
    output logic [7:0]             o_m_axis_tdata,
    output logic                   o_m_axis_tlast,
    output logic [PW-1:0]          o_active_port,
    output logic [COUNT_WIDTH-1:0] o_frame_count
);
    typedef enum logic {ARB, LOCKED} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     grant, grant_nx;
    logic [PW-1:0]     last_grant, last_grant_nx;
    logic [7:0]        s_byte [NUM_PORTS];
    logic              push, pop, full;
    logic              skid_valid, skid_last;
    logic [7:0]        skid_data;

    // first requester after the previous owner, wrapping around the port list
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [PW-1:0] last);
        logic [PW-1:0] sel;
        logic [PW-1:0] idx;
        sel = last;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = PW'((int'(last) + i) % NUM_PORTS);
            if (req[idx]) sel = idx;
        end
        return sel;
    endfunction

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign s_byte[g] = i_s_axis_tdata[8*g +: 8];
    end

    assign pop           = o_m_axis_tvalid & i_m_axis_tready;
    assign full          = o_m_axis_tvalid & skid_valid;
    assign o_active_port = (state == LOCKED) ? grant : '0;

    // arbitration state, current owner and rotation pointer
    always_ff @(posedge i_clk_dbg or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= PW'(NUM_PORTS - 1);
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
        end
    end

    // grant on any request, then hold the owner until its tlast beat is taken
    always_comb begin
        state_nx        = state;
        grant_nx        = grant;
        last_grant_nx   = last_grant;
        o_s_axis_tready = '0;
        push            = 1'b0;
        if (state == ARB) begin
            if (|i_s_axis_tvalid) begin
                grant_nx = rr_pick(i_s_axis_tvalid, last_grant);
                state_nx = LOCKED;
            end
        end else begin
            o_s_axis_tready[grant] = ~full;
            push                   = i_s_axis_tvalid[grant] & ~full;
            if (push && i_s_axis_tlast[grant]) begin
                last_grant_nx = grant;
                state_nx      = ARB;
            end
        end
    end

    // two-entry slice: output register refills from skid first, skid only fills on a stall
    always_ff @(posedge i_clk_dbg or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= '0;
            o_m_axis_tlast  <= 1'b0;
            skid_valid      <= 1'b0;
            skid_data       <= '0;
            skid_last       <= 1'b0;
        end else if (pop || !o_m_axis_tvalid) begin
            if (skid_valid) begin
                o_m_axis_tvalid <= 1'b1;
                o_m_axis_tdata  <= skid_data;
                o_m_axis_tlast  <= skid_last;
                skid_valid      <= 1'b0;
            end else begin
                o_m_axis_tvalid <= push;
                if (push) begin
                    o_m_axis_tdata <= s_byte[grant];
                    o_m_axis_tlast <= i_s_axis_tlast[grant];
                end
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= s_byte[grant];
            skid_last  <= i_s_axis_tlast[grant];
        end
    end

    // count frames whose last byte has left on the master port
    always_ff @(posedge i_clk_dbg or negedge i_rst_n) begin
        if (!i_rst_n) o_frame_count <= '0;
        else if (pop && o_m_axis_tlast) o_frame_count <= o_frame_count + COUNT_WIDTH'(1);
    end
endmodule
